// File: rtl/ponylink_crc32_check.sv
// rtl/ponylink_crc32_check.sv - receive-side CRC-32 frame checker
// Strips the trailing 4 CRC bytes, forwards the payload and reports a per-frame verdict.
module ponylink_crc32_check #(
  parameter int unsigned MAX_PAYLOAD = 1024,
  parameter int unsigned LEN_BITS    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic                out_last,
  output logic                frame_done,
  output logic                frame_ok,
  output logic                frame_err_short,
  output logic                frame_err_long,
  output logic [LEN_BITS-1:0] frame_len
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  localparam logic [31:0] POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  logic [1:0]          state_q, state_d;
  logic [2:0]          fc_q, fc_d;
  logic [3:0][7:0]     sr_q, sr_d;
  logic [31:0]         crc_q, crc_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                short_q, short_d;
  logic                long_q, long_d;
  logic                ov_q, ov_d;
  logic [7:0]          od_q, od_d;
  logic                ol_q, ol_d;
  logic                run_q;
  logic                accept;
  logic                report_exit;

  // MSB-first, unreflected; must stay bit-identical to the transmit generator
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign in_ready    = run_q && (state_q != REPORT) && (!ov_q || out_ready);
  assign accept      = in_valid && in_ready;
  // Hold REPORT until the out_last byte has left so the verdict trails it
  assign report_exit = (state_q == REPORT) && !ov_q;

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    sr_d    = sr_q;
    crc_d   = crc_q;
    len_d   = len_q;
    short_d = short_q;
    long_d  = long_q;
    ov_d    = ov_q && !out_ready;
    od_d    = od_q;
    ol_d    = ol_q;
    if (abort || report_exit) begin
      state_d = IDLE;
      fc_d    = 3'd0;
      crc_d   = CRC_INIT;
      len_d   = '0;
      short_d = 1'b0;
      long_d  = 1'b0;
    end else if (accept) begin
      sr_d = {in_data, sr_q[3:1]};
      if (fc_q == 3'd4) begin
        ov_d  = 1'b1;
        od_d  = sr_q[0];
        ol_d  = in_last;
        crc_d = crc_byte(crc_q, sr_q[0]);
        if (len_q != '1) len_d = len_q + 1'b1;
        if (32'(len_d) > MAX_PAYLOAD) long_d = 1'b1;
      end else begin
        fc_d = fc_q + 3'd1;
      end
      if (in_last) begin
        state_d = REPORT;
        short_d = (fc_q != 3'd4);
      end else if (fc_d == 3'd4) begin
        state_d = STREAM;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fc_q    <= 3'd0;
      sr_q    <= '0;
      crc_q   <= CRC_INIT;
      len_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= 8'd0;
      ol_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      sr_q    <= sr_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      short_q <= short_d;
      long_q  <= long_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      run_q   <= 1'b1;
    end
  end

  assign out_valid       = ov_q;
  assign out_data        = od_q;
  assign out_last        = ol_q;
  assign frame_done      = report_exit && !abort;
  assign frame_ok        = frame_done && (sr_q == crc_q) && !short_q && !long_q;
  assign frame_err_short = frame_done && short_q;
  assign frame_err_long  = frame_done && long_q;
  assign frame_len       = len_q;

endmodule
